// File: rtl/noc_params.sv
// noc_params: shared NoC flit format, label encoding and field widths.
package noc_params;
    localparam int COORD_W = 2;
    localparam int PAYLOAD_W = 32;
    localparam int VC_ID_W = 2;
    typedef enum logic [1:0] {HEAD = 2'd0, BODY = 2'd1, TAIL = 2'd2, HEADTAIL = 2'd3} flit_label_t;
    typedef struct packed {
        flit_label_t label;
        logic [VC_ID_W-1:0] vc_id;
        logic [COORD_W-1:0] x_dest;
        logic [COORD_W-1:0] y_dest;
        logic [PAYLOAD_W-1:0] data;
    } flit_t;
endpackage

// File: rtl/rr_vc_picker.sv
// rr_vc_picker: round-robin grant over a request vector, searching from last+1.
module rr_vc_picker #(
    parameter int N = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);
    logic [IW-1:0] w_k;
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_k = '0;
        for (int i = 1; i <= N; i++) begin
            w_k = IW'((int'(i_last) + i) % N);
            if (!o_any && i_req[w_k]) begin
                o_any = 1'b1;
                o_gnt[w_k] = 1'b1;
                o_idx = w_k;
            end
        end
    end
endmodule

// File: rtl/packet_injector.sv
// packet_injector: turns core header/payload requests into HEAD/BODY/TAIL flits
// on a round-robin chosen VC of the router LOCAL port.
module packet_injector
    import noc_params::*;
#(
    parameter int VC_NUM = 2,
    parameter int MAX_PKT_LEN = 8,
    parameter int LEN_W = $clog2(MAX_PKT_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [COORD_W-1:0]   dest_x_i,
    input  logic [COORD_W-1:0]   dest_y_i,
    input  logic [LEN_W-1:0]     len_i,
    input  logic                 payload_valid_i,
    output logic                 payload_ready_o,
    input  logic [PAYLOAD_W-1:0] payload_i,
    output flit_t                data_o,
    output logic                 valid_flit_o,
    input  logic [VC_NUM-1:0]    on_off_i,
    input  logic [VC_NUM-1:0]    is_allocatable_i,
    output logic                 busy_o,
    output logic                 error_o
);
    localparam int VC_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    typedef enum logic [1:0] {IDLE, VC_SEL, SEND} state_t;
    state_t r_state, w_next;
    logic [VC_W-1:0] r_last_vc, r_vc, w_idx;
    logic [LEN_W-1:0] r_len, r_rem;
    logic [COORD_W-1:0] r_dx, r_dy;
    logic r_err, w_any, w_hdr, w_bad, w_head, w_body;
    logic [VC_NUM-1:0] w_gnt;
    rr_vc_picker #(.N(VC_NUM), .IW(VC_W)) u_pick (
        .i_req(is_allocatable_i),
        .i_last(r_last_vc),
        .o_gnt(w_gnt),
        .o_idx(w_idx),
        .o_any(w_any)
    );
    assign req_ready_o = (r_state == IDLE);
    assign busy_o = (r_state != IDLE);
    assign error_o = r_err;
    assign w_hdr = req_valid_i && req_ready_o;
    assign w_bad = len_i > LEN_W'(MAX_PKT_LEN);
    assign w_head = (r_state == VC_SEL) && w_any && on_off_i[w_idx];
    assign payload_ready_o = (r_state == SEND) && on_off_i[r_vc];
    assign w_body = payload_ready_o && payload_valid_i;
    assign valid_flit_o = w_head || w_body;
    always_comb begin
        data_o = '0;
        if (w_head) begin
            data_o.label = (r_len == '0) ? HEADTAIL : HEAD;
            data_o.vc_id = VC_ID_W'(w_idx);
            data_o.x_dest = r_dx;
            data_o.y_dest = r_dy;
        end else if (w_body) begin
            data_o.label = (r_rem == LEN_W'(1)) ? TAIL : BODY;
            data_o.vc_id = VC_ID_W'(r_vc);
            data_o.data = payload_i;
        end
    end
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = (w_hdr && !w_bad) ? VC_SEL : IDLE;
            VC_SEL:  w_next = !w_head ? VC_SEL : (r_len == '0) ? IDLE : SEND;
            SEND:    w_next = (w_body && r_rem == LEN_W'(1)) ? IDLE : SEND;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else r_state <= w_next;
    end
    // Oversized headers are swallowed and only flagged one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_vc <= VC_W'(VC_NUM - 1);
            r_vc <= '0;
            r_len <= '0;
            r_rem <= '0;
            r_dx <= '0;
            r_dy <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_hdr && w_bad;
            if (w_hdr && !w_bad) begin
                r_len <= len_i;
                r_rem <= len_i;
                r_dx <= dest_x_i;
                r_dy <= dest_y_i;
            end
            if (w_head) begin
                r_vc <= w_idx;
                r_last_vc <= w_idx;
            end
            if (w_body) r_rem <= r_rem - LEN_W'(1);
        end
    end
endmodule
